// File: rtl/padded16_stencil_window_gen.sv
// ---------------------------------------------------------------------------
// padded16_stencil_window_gen
//
// Purpose: turns a row-major stream of signed 16-bit pixels into 6-tap
// Sobel-x windows for a downstream gradient compute unit. Two line buffers
// hold rows r-1 and r-2 of the frame. Two 3-entry column shift registers
// hold columns c-1 and c-2 of rows r, r-1 and r-2. A window is emitted for
// every accepted pixel at row >= 2 and column >= 2. Each window is centred
// one row up and one column left of that pixel.
//
// Ports:
//   clk            clock, rising edge
//   reset          asynchronous active-high reset
//   in_valid       in_pixel is valid
//   in_ready       block accepts in_pixel this cycle (!out_valid || out_ready)
//   in_pixel[15:0] signed pixel, row-major, frame-ordered
//   out_valid      out_tap0..5 hold a valid window
//   out_ready      downstream consumes the window
//   out_tap0..5    window taps:
//                    tap0 = P(r-2,c)    tap1 = P(r,c)      tap2 = P(r-1,c)
//                    tap3 = P(r-2,c-2)  tap4 = P(r-1,c-2)  tap5 = P(r,c-2)
//   frame_done     one-cycle pulse on the transfer of a frame's last window
// ---------------------------------------------------------------------------
module padded16_stencil_window_gen #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_pixel,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_tap0,
  output logic [15:0] out_tap1,
  output logic [15:0] out_tap2,
  output logic [15:0] out_tap3,
  output logic [15:0] out_tap4,
  output logic [15:0] out_tap5,
  output logic        frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  // Position of the next pixel to be accepted.
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;

  // Line buffers: r_lb1 holds row r-1 and r_lb2 holds row r-2, indexed by column.
  logic [15:0] r_lb1 [IMG_W];
  logic [15:0] r_lb2 [IMG_W];

  // Column shift registers. Entry 0 is row r, 1 is row r-1, 2 is row r-2.
  // r_sh1 holds column c-1 and r_sh2 holds column c-2.
  logic [15:0] r_sh1 [3];
  logic [15:0] r_sh2 [3];

  logic [15:0] r_tap [6];
  logic        r_out_valid;
  logic        r_last;

  logic        w_accept;
  logic        w_win;
  logic        w_last;
  logic [15:0] w_lb1_rd;
  logic [15:0] w_lb2_rd;
  logic [15:0] w_col_new [3];
  logic [15:0] w_tap_next [6];

  // A single registered output stage. A new pixel can enter whenever the
  // held window is empty or is leaving on this same edge.
  assign in_ready   = !r_out_valid || out_ready;
  assign w_accept   = in_valid && in_ready;
  assign out_valid  = r_out_valid;
  assign frame_done = r_out_valid && out_ready && r_last;

  // Read the line buffers at the current column before this cycle's write.
  assign w_lb1_rd = r_lb1[r_col];
  assign w_lb2_rd = r_lb2[r_col];

  // Gating on row >= 2 also keeps the previous frame's line data out of
  // this frame's windows.
  assign w_win  = w_accept && (r_row >= RW'(2)) && (r_col >= CW'(2));
  assign w_last = (r_row == ROW_LAST) && (r_col == COL_LAST);

  assign w_col_new[0] = in_pixel;
  assign w_col_new[1] = w_lb1_rd;
  assign w_col_new[2] = w_lb2_rd;

  assign w_tap_next[0] = w_lb2_rd;
  assign w_tap_next[1] = in_pixel;
  assign w_tap_next[2] = w_lb1_rd;
  assign w_tap_next[3] = r_sh2[2];
  assign w_tap_next[4] = r_sh2[1];
  assign w_tap_next[5] = r_sh2[0];

  // Line-buffer RAM. It is not reset because its contents are only used
  // after two fresh rows have been written.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb1[r_col] <= in_pixel;
      r_lb2[r_col] <= w_lb1_rd;
    end
  end

  // At column 0 the c-2 column is cleared. Windows are only taken from
  // column 2 onward, so no window mixes columns from two rows.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_shift
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_sh1[gi] <= '0;
          r_sh2[gi] <= '0;
        end else if (w_accept) begin
          r_sh1[gi] <= w_col_new[gi];
          r_sh2[gi] <= (r_col == '0) ? 16'h0000 : r_sh1[gi];
        end
      end
    end
  endgenerate

  // Output taps only load when a window is produced. While a window is
  // stalled no pixel is accepted, so the taps hold.
  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_tap
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_tap[gi] <= '0;
        end else if (w_win) begin
          r_tap[gi] <= w_tap_next[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col       <= '0;
      r_row       <= '0;
      r_out_valid <= 1'b0;
      r_last      <= 1'b0;
    end else begin
      if (w_accept) begin
        if (r_col == COL_LAST) begin
          r_col <= '0;
          r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
      if (w_win) begin
        r_out_valid <= 1'b1;
        r_last      <= w_last;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_tap0 = r_tap[0];
  assign out_tap1 = r_tap[1];
  assign out_tap2 = r_tap[2];
  assign out_tap3 = r_tap[3];
  assign out_tap4 = r_tap[4];
  assign out_tap5 = r_tap[5];

endmodule

// File: doc/padded16_stencil_window_gen.md
PADDED16_STENCIL_WINDOW_GEN -- requirements
Module: padded16_stencil_window_gen

Interface
REQ-001 The block SHALL have parameter IMG_W, default 64, meaning pixels per row (range 3..1024).
REQ-002 The block SHALL have parameter IMG_H, default 64, meaning rows per frame (range 3..1024).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_pixel is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block accepts in_pixel this cycle.
REQ-007 The block SHALL have port in_pixel, input, 16 bits: signed pixel, row-major, frame-ordered.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_tap0..5 hold a valid window.
REQ-009 The block SHALL have port out_ready, input, 1 bit: downstream compute unit consumes the window.
REQ-010 The block SHALL have ports out_tap0..out_tap5, output, 16 bits each: the 6-tap Sobel-x window for the gradient compute unit.
REQ-011 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse when the last window of a frame is consumed.

Function
REQ-012 An input transfer SHALL occur on a cycle with in_valid && in_ready; an output transfer on out_valid && out_ready.
REQ-013 in_ready SHALL be combinational: !out_valid || out_ready (single registered output stage, no combinational valid path).
REQ-014 The block SHALL keep column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) for the next accepted pixel; col increments per input transfer, wraps to 0 and increments row at IMG_W-1; row wraps to 0 after (IMG_H-1, IMG_W-1).
REQ-015 The block SHALL hold two line buffers of IMG_W x 16 bits (rows r-1, r-2) plus two 3-entry column shift registers giving columns c-1 and c-2 of rows r, r-1, r-2.
REQ-016 On accepting pixel p at (r,c) with r>=2 and c>=2, the block SHALL register the window centred at (r-1,c-1) into the outputs and set out_valid=1 on the next edge.
REQ-017 Tap mapping SHALL be: tap0=P(r-2,c), tap1=P(r,c), tap2=P(r-1,c), tap3=P(r-2,c-2), tap4=P(r-1,c-2), tap5=P(r,c-2), where P(y,x) is the pixel at row y, column x.
REQ-018 Accepted pixels with r<2 or c<2 SHALL update line buffers/shift registers only and SHALL NOT raise out_valid.
REQ-019 Column shift registers SHALL be cleared logically at each row start: windows never mix columns from different rows.
REQ-020 Windows per frame SHALL be exactly (IMG_W-2)*(IMG_H-2), emitted in row-major order of centre.
REQ-021 out_valid SHALL drop to 0 after an output transfer unless a new window is loaded on the same edge (simultaneous output transfer and window-producing input transfer yields back-to-back valid).
REQ-022 While out_valid && !out_ready, out_tap0..5 SHALL remain stable and no input SHALL be accepted.
REQ-023 frame_done SHALL pulse for one cycle on the output transfer of the window centred at (IMG_H-2, IMG_W-2).
REQ-024 Line-buffer contents from a previous frame SHALL never appear in a window of the next frame (row<2 gating guarantees this).
REQ-025 Data SHALL pass through unmodified: no arithmetic, sign extension or clamping on taps.
REQ-026 Sustained throughput SHALL be one pixel per cycle when out_ready is held 1.

Reset
REQ-027 While reset is high: out_valid=0, frame_done=0, out_tap0..5=0, col=0, row=0; in_ready=1 on the first cycle after release.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame; the first pixel after release is treated as (0,0).
REQ-029 Line-buffer RAM contents SHALL NOT require reset.

Verification
REQ-030 IMG_W=4, IMG_H=4, pixel=16*row+col, out_ready=1 -> first window: taps 2,34,18,0,16,32; four windows total; frame_done once.
REQ-031 Same stream, out_ready held 0 for 5 cycles at first window -> taps stable, in_ready=0, no pixels lost; remaining windows correct.
REQ-032 Two back-to-back frames with different data (second frame +0x100) -> second-frame first window taps 0x102,0x122,0x112,0x100,0x110,0x120; no first-frame values.
REQ-033 Reset pulsed after 9 pixels of a frame, then a full frame -> exactly 4 windows, values as REQ-030.
REQ-034 Random in_valid/out_ready (50%), IMG_W=8, IMG_H=6 -> 24 windows matching a software model; frame_done once per frame.
REQ-035 Signed extremes (0x8000, 0x7FFF) in input -> taps reproduce them bit-exact.
